mem_wb_writeback: RTL and testbench
===================================

// Module: mem_wb_writeback
// PURPOSE
//  MEM/WB pipeline register plus writeback logic of the 5-stage MIPS pipeline; the write-side initiator of register_file.
//  Captures MEM-stage results, aligns/extends load data, selects ALU vs load result.
//  Drives the register file write port (reg_write_en/dest/data), which also serves as the WB forwarding source.
//  Guarantees exactly one write per retired instruction, even while stalled.
// PARAMETERS
//  DATA_W      32  datapath / register width
//  REG_ADDR_W  5   register index width
//  CNT_W       32  retire counter width (only with WB_RETIRE_CNT_EN)
// PORTS
//  clk             in   1           pipeline clock, posedge
//  reset           in   1           asynchronous, active-high
//  mem_valid       in   1           MEM stage holds a real instruction (0 = bubble)
//  mem_reg_write   in   1           instruction writes a register
//  mem_mem_to_reg  in   1           1 = result from load data, 0 = from ALU
//  mem_load_type   in   3           000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU, 101-111 treated as LW
//  mem_addr_lo     in   2           effective address [1:0] for byte/half select
//  mem_dest        in   REG_ADDR_W  destination register
//  mem_alu_result  in   DATA_W      ALU result
//  mem_load_data   in   DATA_W      raw word read from data memory
//  wb_stall        in   1           hold WB register contents
//  wb_flush        in   1           invalidate WB register
//  reg_write_en    out  1           register file write strobe
//  reg_write_dest  out  REG_ADDR_W  register file write index
//  reg_write_data  out  DATA_W      register file write data
//  wb_valid        out  1           WB register holds a real instruction
//  retire_count    out  CNT_W       retired-instruction count (only with WB_RETIRE_CNT_EN)
// BEHAVIOUR
//  - Reset (async, immediate): wb_valid=0, stored dest/data/ctrl=0, written flag=0.
//    Outputs read 0: reg_write_en=0, reg_write_dest=0, reg_write_data=0, retire_count=0.
//  - Per posedge, in priority order:
//    1. flush: wb_valid<=0, written<=0. Flush beats stall.
//    2. stall: hold all state; written<=written|reg_write_en.
//    3. otherwise: load the MEM inputs; wb_valid<=mem_valid, written<=0.
//  - Load extract is applied at capture, so the stored data is the final writeback value.
//    Little-endian lanes.
//    LB/LBU take byte mem_load_data[8*addr_lo +: 8], sign/zero extended.
//    LH/LHU take half mem_load_data[16*addr_lo[1] +: 16]; addr_lo[0] is ignored, no misalign trap.
//    LW ignores addr_lo.
//    When mem_to_reg=0, the ALU result is stored unmodified.
//  - Latency: 1 cycle, from MEM inputs to reg_write_* valid.
//  - reg_write_en = wb_valid & wb_reg_write & (wb_dest!=0) & ~written.
//    Combinational from registers only, no input-to-output path.
//  - Stall longer than 1 cycle: the write strobe asserts in the first cycle only.
//    reg_write_dest/data stay stable for the whole stall.
//  - Bubble (mem_valid=0): no write; stored dest/data are don't-care but are still registered.
//  - Writes to r0 are never strobed, even if mem_reg_write=1.
//  - Flush together with a pending write: the write in the current cycle still happens (already on the port).
//    The entry is dropped at the edge.
// CONFIGURATION
//  WB_RETIRE_CNT_EN defined:
//  - retire_count increments by 1 on every posedge where wb_valid & ~wb_stall & ~wb_flush.
//  - Wraps to 0 at 2^CNT_W-1; reset to 0.
//  - Counts non-writing instructions too.
//  WB_RETIRE_CNT_EN undefined: the port and the counter are absent.
// STRUCTURE
//  - mips_pkg holds:
//    - load_type_e enum (LT_LW, LT_LB, LT_LBU, LT_LH, LT_LHU)
//    - DATA_W / REG_ADDR_W defaults
//    - REG_ZERO constant
//  - Sub-module load_extend: combinational; inputs raw word, addr_lo, load_type; output extended word.
//    Reusable by the MEM stage.
// TESTING
//  1. Reset asserted mid-stall with wb_valid=1 -> all outputs 0 immediately; no write after release.
//  2. ALU op: dest=5, alu=0xDEADBEEF, valid=1 -> next cycle en=1, dest=5, data=0xDEADBEEF; en=0 the cycle after with a bubble.
//  3. load=0x8899AABB:
//     LB addr_lo=2 -> 0xFFFFFF99
//     LBU addr_lo=0 -> 0x000000BB
//     LH addr_lo=3 -> 0xFFFF8899
//     LHU addr_lo=0 -> 0x0000AABB
//     type=111 -> 0x8899AABB
//  4. Write to dest=0 with reg_write=1 -> en stays 0; wb_valid=1; retire_count (if enabled) increments.
//  5. Capture dest=7, then stall 3 cycles -> en=1 only in cycle 1; dest/data held; release -> next instruction captured.
//  6. flush+stall in the same cycle -> wb_valid=0 next cycle, en=0.
//     With WB_RETIRE_CNT_EN: count unchanged on flush; counter at 0xFFFFFFFF wraps to 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and defaults for the 5-stage MIPS pipeline datapath.
package mips_pkg;

  localparam int DEFAULT_DATA_W     = 32;
  localparam int DEFAULT_REG_ADDR_W = 5;
  localparam int REG_ZERO           = 0;

  // Encodings 101-111 are not named and fall back to a plain word load.
  typedef enum logic [2:0] {
    LT_LW  = 3'b000,
    LT_LB  = 3'b001,
    LT_LBU = 3'b010,
    LT_LH  = 3'b011,
    LT_LHU = 3'b100
  } load_type_e;

endpackage

// File: rtl/load_extend.sv
// Little-endian byte/half lane select with sign or zero extension of a loaded word.
// Purely combinational so the MEM stage can reuse it.
module load_extend
  import mips_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic [DATA_W-1:0] raw,
  input  logic [1:0]        addr_lo,
  input  logic [2:0]        load_type,
  output logic [DATA_W-1:0] ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Halfword lanes ignore addr_lo[0]: a misaligned LH reads its containing half.
  assign byte_sel = raw[{addr_lo, 3'b000} +: 8];
  assign half_sel = raw[{addr_lo[1], 4'b0000} +: 16];

  // NOTE: ext gets a default before the case so every path assigns it and no latch is inferred.
  always_comb begin
    ext = raw;
    case (load_type_e'(load_type))
      LT_LB:   ext = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      LT_LBU:  ext = {{(DATA_W-8){1'b0}}, byte_sel};
      LT_LH:   ext = {{(DATA_W-16){half_sel[15]}}, half_sel};
      LT_LHU:  ext = {{(DATA_W-16){1'b0}}, half_sel};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register and register-file write port; one write strobe per retired instruction.
// Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
module mem_wb_writeback
  import mips_pkg::*;
#(
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W
`ifdef WB_RETIRE_CNT_EN
  , parameter int CNT_W    = 32
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_valid,
  input  logic                  mem_reg_write,
  input  logic                  mem_mem_to_reg,
  input  logic [2:0]            mem_load_type,
  input  logic [1:0]            mem_addr_lo,
  input  logic [REG_ADDR_W-1:0] mem_dest,
  input  logic [DATA_W-1:0]     mem_alu_result,
  input  logic [DATA_W-1:0]     mem_load_data,
  input  logic                  wb_stall,
  input  logic                  wb_flush,
  output logic                  reg_write_en,
  output logic [REG_ADDR_W-1:0] reg_write_dest,
  output logic [DATA_W-1:0]     reg_write_data,
  output logic                  wb_valid
`ifdef WB_RETIRE_CNT_EN
  , output logic [CNT_W-1:0]    retire_count
`endif
);

  logic                  wb_reg_write;
  logic [REG_ADDR_W-1:0] wb_dest;
  logic [DATA_W-1:0]     wb_data;
  logic                  written;
  logic [DATA_W-1:0]     load_ext;

  load_extend #(.DATA_W(DATA_W)) u_load_extend (
    .raw       (mem_load_data),
    .addr_lo   (mem_addr_lo),
    .load_type (mem_load_type),
    .ext       (load_ext)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_dest      <= '0;
      wb_data      <= '0;
      written      <= 1'b0;
    end else if (wb_flush) begin
      wb_valid <= 1'b0;
      written  <= 1'b0;
    end else if (wb_stall) begin
      // Remember that this entry already wrote so a long stall cannot write twice.
      written <= written | reg_write_en;
    end else begin
      wb_valid     <= mem_valid;
      wb_reg_write <= mem_reg_write;
      wb_dest      <= mem_dest;
      wb_data      <= mem_mem_to_reg ? load_ext : mem_alu_result;
      written      <= 1'b0;
    end
  end

  assign reg_write_en   = wb_valid & wb_reg_write
                        & (wb_dest != REG_ADDR_W'(REG_ZERO)) & ~written;
  assign reg_write_dest = wb_dest;
  assign reg_write_data = wb_data;

`ifdef WB_RETIRE_CNT_EN
  // Counts every instruction leaving WB, including non-writing ones; wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retire_count <= '0;
    end else if (wb_valid & ~wb_stall & ~wb_flush) begin
      retire_count <= retire_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Self-checking bench for mem_wb_writeback: vector table with scoreboard plus stall/flush/reset sequences.
module tb_mem_wb_writeback;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid, mem_reg_write, mem_mem_to_reg;
  logic [2:0]  mem_load_type;
  logic [1:0]  mem_addr_lo;
  logic [4:0]  mem_dest;
  logic [31:0] mem_alu_result, mem_load_data;
  logic        wb_stall, wb_flush;
  logic        reg_write_en, wb_valid;
  logic [4:0]  reg_write_dest;
  logic [31:0] reg_write_data;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_count;
  logic        en_s, valid_s;
  logic [4:0]  dest_s;
  logic [31:0] data_s;
  logic [3:0]  retire_count_s;
`endif

  int checks = 0;
  int errors = 0;
  logic        m_valid;
  logic [31:0] exp_cnt;

  always #5 clk = ~clk;

  mem_wb_writeback dut (
    .clk            (clk),
    .reset          (reset),
    .mem_valid      (mem_valid),
    .mem_reg_write  (mem_reg_write),
    .mem_mem_to_reg (mem_mem_to_reg),
    .mem_load_type  (mem_load_type),
    .mem_addr_lo    (mem_addr_lo),
    .mem_dest       (mem_dest),
    .mem_alu_result (mem_alu_result),
    .mem_load_data  (mem_load_data),
    .wb_stall       (wb_stall),
    .wb_flush       (wb_flush),
    .reg_write_en   (reg_write_en),
    .reg_write_dest (reg_write_dest),
    .reg_write_data (reg_write_data),
    .wb_valid       (wb_valid)
`ifdef WB_RETIRE_CNT_EN
    , .retire_count (retire_count)
`endif
  );

`ifdef WB_RETIRE_CNT_EN
  // Narrow counter copy so wrap-around is reachable in a short run.
  mem_wb_writeback #(.CNT_W(4)) dut_small (
    .clk            (clk),
    .reset          (reset),
    .mem_valid      (mem_valid),
    .mem_reg_write  (mem_reg_write),
    .mem_mem_to_reg (mem_mem_to_reg),
    .mem_load_type  (mem_load_type),
    .mem_addr_lo    (mem_addr_lo),
    .mem_dest       (mem_dest),
    .mem_alu_result (mem_alu_result),
    .mem_load_data  (mem_load_data),
    .wb_stall       (wb_stall),
    .wb_flush       (wb_flush),
    .reg_write_en   (en_s),
    .reg_write_dest (dest_s),
    .reg_write_data (data_s),
    .wb_valid       (valid_s),
    .retire_count   (retire_count_s)
  );
`endif

  typedef struct packed {
    logic        valid, rw, m2r;
    logic [2:0]  lt;
    logic [1:0]  alo;
    logic [4:0]  dest;
    logic [31:0] alu, ld;
    logic        e_en, e_valid, chk;
    logic [4:0]  e_dest;
    logic [31:0] e_data;
  } vec_t;

  typedef struct packed {
    logic        en, valid, chk;
    logic [4:0]  dest;
    logic [31:0] data;
  } exp_t;

  vec_t vecs[20];
  exp_t sb[$];

  localparam logic [31:0] LD = 32'h8899AABB;
  localparam logic [31:0] LP = 32'h12345678;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_cnt(input string name);
`ifdef WB_RETIRE_CNT_EN
    check({name, "_cnt"}, retire_count, exp_cnt);
    check({name, "_cnt4"}, {28'b0, retire_count_s}, {28'b0, exp_cnt[3:0]});
`else
    if (name.len() < 0) $display("%s", name);
`endif
  endtask

  function automatic vec_t mk(input logic valid, rw, m2r, input logic [2:0] lt,
                              input logic [1:0] alo, input logic [4:0] dest,
                              input logic [31:0] alu, ld, input logic e_en, e_valid, chk,
                              input logic [4:0] e_dest, input logic [31:0] e_data);
    vec_t v;
    v = '{valid, rw, m2r, lt, alo, dest, alu, ld, e_en, e_valid, chk, e_dest, e_data};
    return v;
  endfunction

  task automatic set_in(input logic valid, rw, m2r, input logic [2:0] lt, input logic [1:0] alo,
                        input logic [4:0] dest, input logic [31:0] alu, ld);
    mem_valid      = valid;
    mem_reg_write  = rw;
    mem_mem_to_reg = m2r;
    mem_load_type  = lt;
    mem_addr_lo    = alo;
    mem_dest       = dest;
    mem_alu_result = alu;
    mem_load_data  = ld;
  endtask

  // One clock edge; the expected valid/retire model follows the same edge using bench inputs.
  task automatic tick();
    @(posedge clk);
    if (m_valid && !wb_stall && !wb_flush) exp_cnt++;
    m_valid = wb_flush ? 1'b0 : (wb_stall ? m_valid : mem_valid);
    @(negedge clk);
  endtask

  task automatic chk_out(input string name, input logic en, valid, input logic [4:0] dest,
                         input logic [31:0] data);
    check({name, "_en"}, {31'b0, reg_write_en}, {31'b0, en});
    check({name, "_valid"}, {31'b0, wb_valid}, {31'b0, valid});
    check({name, "_dest"}, {27'b0, reg_write_dest}, {27'b0, dest});
    check({name, "_data"}, reg_write_data, data);
  endtask

  initial begin
    vecs[0]  = mk(1,1,0,3'd0,2'd0,5'd5, 32'hDEADBEEF,32'h0, 1,1,1,5'd5, 32'hDEADBEEF);
    vecs[1]  = mk(0,1,0,3'd0,2'd0,5'd5, 32'hDEADBEEF,32'h0, 0,0,0,5'd0, 32'h0);
    vecs[2]  = mk(1,1,1,3'd1,2'd2,5'd1, 32'h0,LD, 1,1,1,5'd1, 32'hFFFFFF99);
    vecs[3]  = mk(1,1,1,3'd2,2'd0,5'd2, 32'h0,LD, 1,1,1,5'd2, 32'h000000BB);
    vecs[4]  = mk(1,1,1,3'd3,2'd3,5'd3, 32'h0,LD, 1,1,1,5'd3, 32'hFFFF8899);
    vecs[5]  = mk(1,1,1,3'd4,2'd0,5'd4, 32'h0,LD, 1,1,1,5'd4, 32'h0000AABB);
    vecs[6]  = mk(1,1,1,3'd7,2'd1,5'd6, 32'h0,LD, 1,1,1,5'd6, 32'h8899AABB);
    vecs[7]  = mk(1,1,1,3'd1,2'd1,5'd8, 32'h0,LD, 1,1,1,5'd8, 32'hFFFFFFAA);
    vecs[8]  = mk(1,1,1,3'd2,2'd3,5'd9, 32'h0,LD, 1,1,1,5'd9, 32'h00000088);
    vecs[9]  = mk(1,1,1,3'd3,2'd0,5'd10,32'h0,LD, 1,1,1,5'd10,32'hFFFFAABB);
    vecs[10] = mk(1,1,1,3'd4,2'd2,5'd11,32'h0,LD, 1,1,1,5'd11,32'h00008899);
    vecs[11] = mk(1,1,1,3'd3,2'd1,5'd12,32'h0,LD, 1,1,1,5'd12,32'hFFFFAABB);
    vecs[12] = mk(1,1,1,3'd0,2'd2,5'd13,32'h0,LD, 1,1,1,5'd13,32'h8899AABB);
    vecs[13] = mk(1,1,1,3'd1,2'd0,5'd14,32'h0,LP, 1,1,1,5'd14,32'h00000078);
    vecs[14] = mk(1,1,1,3'd3,2'd2,5'd15,32'h0,LP, 1,1,1,5'd15,32'h00001234);
    vecs[15] = mk(1,1,0,3'd0,2'd0,5'd0, 32'h55,LD, 0,1,1,5'd0, 32'h00000055);
    vecs[16] = mk(1,0,0,3'd0,2'd0,5'd3, 32'h66,LD, 0,1,1,5'd3, 32'h00000066);
    vecs[17] = mk(1,1,0,3'd1,2'd1,5'd31,32'hCAFEF00D,LD, 1,1,1,5'd31,32'hCAFEF00D);
    vecs[18] = mk(1,1,1,3'd5,2'd3,5'd17,32'h0,LD, 1,1,1,5'd17,32'h8899AABB);
    vecs[19] = mk(1,1,1,3'd6,2'd2,5'd18,32'h0,LD, 1,1,1,5'd18,32'h8899AABB);

    // Reset state
    reset = 1'b1;
    wb_stall = 1'b0;
    wb_flush = 1'b0;
    set_in(1, 1, 0, 3'd0, 2'd0, 5'd9, 32'h12121212, LD);
    m_valid = 1'b0;
    exp_cnt = '0;
    repeat (2) @(negedge clk);
    chk_out("reset", 0, 0, 5'd0, 32'h0);
    chk_cnt("reset");
    reset = 1'b0;

    // Vector table through the scoreboard
    for (int i = 0; i < 20; i++) begin
      exp_t e;
      set_in(vecs[i].valid, vecs[i].rw, vecs[i].m2r, vecs[i].lt, vecs[i].alo,
             vecs[i].dest, vecs[i].alu, vecs[i].ld);
      sb.push_back('{vecs[i].e_en, vecs[i].e_valid, vecs[i].chk, vecs[i].e_dest, vecs[i].e_data});
      tick();
      e = sb.pop_front();
      check($sformatf("v%0d_en", i), {31'b0, reg_write_en}, {31'b0, e.en});
      check($sformatf("v%0d_valid", i), {31'b0, wb_valid}, {31'b0, e.valid});
      if (e.chk) begin
        check($sformatf("v%0d_dest", i), {27'b0, reg_write_dest}, {27'b0, e.dest});
        check($sformatf("v%0d_data", i), reg_write_data, e.data);
      end
      chk_cnt($sformatf("v%0d", i));
    end

    // Capture dest 7, then stall three edges: one strobe, payload held
    set_in(1, 1, 0, 3'd0, 2'd0, 5'd7, 32'h77777777, LD);
    tick();
    chk_out("stall_c1", 1, 1, 5'd7, 32'h77777777);
    wb_stall = 1'b1;
    set_in(1, 1, 0, 3'd0, 2'd0, 5'd9, 32'h99999999, LD);
    for (int k = 2; k <= 4; k++) begin
      tick();
      chk_out($sformatf("stall_c%0d", k), 0, 1, 5'd7, 32'h77777777);
      chk_cnt($sformatf("stall_c%0d", k));
    end
    wb_stall = 1'b0;
    tick();
    chk_out("stall_rel", 1, 1, 5'd9, 32'h99999999);
    chk_cnt("stall_rel");

    // Flush together with stall while a write is on the port
    set_in(1, 1, 0, 3'd0, 2'd0, 5'd4, 32'h44444444, LD);
    tick();
    wb_stall = 1'b1;
    wb_flush = 1'b1;
    #1;
    check("flush_pending_en", {31'b0, reg_write_en}, 32'd1);
    tick();
    check("flush_stall_en", {31'b0, reg_write_en}, 32'd0);
    check("flush_stall_valid", {31'b0, wb_valid}, 32'd0);
    chk_cnt("flush_stall");
    wb_stall = 1'b0;
    tick();
    check("flush_only_valid", {31'b0, wb_valid}, 32'd0);
    chk_cnt("flush_only");
    wb_flush = 1'b0;
    tick();
    chk_out("after_flush", 1, 1, 5'd4, 32'h44444444);

    // Extra retirements so the narrow counter wraps
    set_in(1, 0, 0, 3'd0, 2'd0, 5'd2, 32'h0, LD);
    repeat (20) tick();
    chk_cnt("wrap");

    // Reset asserted mid-stall with a valid entry
    set_in(1, 1, 0, 3'd0, 2'd0, 5'd6, 32'h66666666, LD);
    tick();
    wb_stall = 1'b1;
    tick();
    check("pre_reset_valid", {31'b0, wb_valid}, 32'd1);
    #2 reset = 1'b1;
    m_valid = 1'b0;
    exp_cnt = '0;
    #1;
    chk_out("reset_async", 0, 0, 5'd0, 32'h0);
    chk_cnt("reset_async");
    #1 reset = 1'b0;
    tick();
    chk_out("reset_release", 0, 0, 5'd0, 32'h0);
    wb_stall = 1'b0;
    tick();
    chk_out("reset_resume", 1, 1, 5'd6, 32'h66666666);
    chk_cnt("reset_resume");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
